// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared prescaler and period counter (edge or center aligned),
// per-channel duty/polarity, double-buffered config applied at period boundaries.
module pwm_lane #(
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  input  logic             invert,
  output logic             pwm_out
);
  always_ff @(posedge clock) begin
    if (!reset_n)    pwm_out <= 1'b0;
    else if (enable) pwm_out <= (cnt < duty) ^ invert;
    else             pwm_out <= invert;
  end
endmodule

module pwm_multi_ch #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 10,
  parameter int PRE_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [PRE_WIDTH-1:0]      prescaler,
  input  logic [WIDTH-1:0]          top,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       invert,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      busy
);
  typedef struct packed {
    logic [PRE_WIDTH-1:0]             pre;
    logic [WIDTH-1:0]                 top;
    logic                             mode;
    logic [CHANNELS-1:0][WIDTH-1:0]   duty;
    logic [CHANNELS-1:0]              inv;
  } cfg_t;

  typedef enum logic {DIR_UP, DIR_DN} dir_t;

  cfg_t                 shd, act;
  logic [PRE_WIDTH-1:0] pre_cnt;
  logic [WIDTH-1:0]     cnt, cnt_nxt;
  dir_t                 dir, dir_nxt;
  logic                 pending, tick, bnd, apply;

  assign tick  = enable && (pre_cnt == act.pre);
  assign bnd   = tick && (cnt_nxt == '0);
  assign apply = pending && (bnd || !enable);
  assign busy  = pending;

  always_comb begin
    cnt_nxt = '0;
    dir_nxt = DIR_UP;
    if (!act.mode) begin
      cnt_nxt = (cnt >= act.top) ? '0 : cnt + WIDTH'(1);
    end else if (act.top != '0) begin
      // direction flips on the tick that lands on either end of the ramp
      if (dir == DIR_UP) begin
        cnt_nxt = cnt + WIDTH'(1);
        dir_nxt = (cnt_nxt >= act.top) ? DIR_DN : DIR_UP;
      end else begin
        cnt_nxt = cnt - WIDTH'(1);
        dir_nxt = (cnt_nxt == '0) ? DIR_UP : DIR_DN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shd          <= '0;
      act          <= '0;
      pre_cnt      <= '0;
      cnt          <= '0;
      dir          <= DIR_UP;
      pending      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= bnd;
      if (!enable) begin
        pre_cnt <= '0;
        cnt     <= '0;
        dir     <= DIR_UP;
      end else if (tick) begin
        pre_cnt <= '0;
        cnt     <= cnt_nxt;
        dir     <= dir_nxt;
      end else begin
        pre_cnt <= pre_cnt + PRE_WIDTH'(1);
      end
      // apply takes the old shadow; a coincident load refills it and stays pending
      if (apply) begin
        act <= shd;
        dir <= DIR_UP;
      end
      if (load) shd <= {prescaler, top, mode, duty, invert};
      pending <= load | (pending & ~apply);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pwm_lane #(.WIDTH(WIDTH)) u_lane (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (enable),
      .cnt     (cnt),
      .duty    (act.duty[i]),
      .invert  (act.inv[i]),
      .pwm_out (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized bench for pwm_multi_ch against a phase-based reference model.
module tb_pwm_multi_ch;
  localparam int CH = 4, W = 10, PW = 32;

  logic          clock = 1'b0, reset_n = 1'b0, enable = 1'b0, load = 1'b0, mode = 1'b0;
  logic [PW-1:0] prescaler = '0;
  logic [W-1:0]  top = '0;
  logic [CH*W-1:0] duty = '0;
  logic [CH-1:0] invert = '0;
  logic [CH-1:0] pwm_out;
  logic          period_start, busy;

  pwm_multi_ch #(.CHANNELS(CH), .WIDTH(W), .PRE_WIDTH(PW)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .load(load),
    .prescaler(prescaler), .top(top), .mode(mode), .duty(duty), .invert(invert),
    .pwm_out(pwm_out), .period_start(period_start), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: position within the period (phase) plus a clock count since last tick.
  int s_pre, s_top, s_mode, s_duty[CH], s_inv[CH];
  int a_pre, a_top, a_mode, a_duty[CH], a_inv[CH];
  int m_clk, m_phase, m_pend;
  logic [CH-1:0] m_out;
  logic m_ps;

  function automatic int m_cnt();
    if (a_mode == 0) return m_phase;
    return (m_phase <= a_top) ? m_phase : 2 * a_top - m_phase;
  endfunction

  task automatic model_step();
    int period, c;
    bit tk, bd, ap;
    if (!reset_n) begin
      s_pre = 0; s_top = 0; s_mode = 0; a_pre = 0; a_top = 0; a_mode = 0;
      for (int i = 0; i < CH; i++) begin s_duty[i] = 0; s_inv[i] = 0; a_duty[i] = 0; a_inv[i] = 0; end
      m_clk = 0; m_phase = 0; m_pend = 0; m_out = '0; m_ps = 1'b0;
      return;
    end
    period = a_mode ? 2 * a_top : a_top + 1;
    if (period < 1) period = 1;
    tk = enable && (m_clk == a_pre);
    bd = tk && (m_phase + 1 == period);
    c  = m_cnt();
    for (int i = 0; i < CH; i++)
      m_out[i] = enable ? ((c < a_duty[i]) != (a_inv[i] != 0)) : (a_inv[i] != 0);
    m_ps = bd;
    if (!enable) begin
      m_clk = 0; m_phase = 0;
    end else begin
      m_clk = tk ? 0 : m_clk + 1;
      if (tk) m_phase = bd ? 0 : m_phase + 1;
    end
    ap = (m_pend != 0) && (bd || !enable);
    if (ap) begin
      a_pre = s_pre; a_top = s_top; a_mode = s_mode;
      for (int i = 0; i < CH; i++) begin a_duty[i] = s_duty[i]; a_inv[i] = s_inv[i]; end
    end
    if (load) begin
      s_pre = int'(prescaler); s_top = int'(top); s_mode = int'(mode);
      for (int i = 0; i < CH; i++) begin s_duty[i] = int'(duty[i*W +: W]); s_inv[i] = int'(invert[i]); end
    end
    m_pend = load ? 1 : (ap ? 0 : m_pend);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("pwm_out", 32'(pwm_out), 32'(m_out));
    chk("period_start", 32'(period_start), 32'(m_ps));
    chk("busy", 32'(busy), 32'(m_pend));
  endtask

  task automatic set_cfg(input int pre, input int tp, input int md,
                         input int d0, input int d1, input int d2, input int d3, input int inv);
    prescaler = PW'(pre); top = W'(tp); mode = md[0];
    duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
    invert = CH'(inv);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  logic seq[12];
  logic edge_exp[8]   = '{1, 1, 0, 0, 1, 1, 0, 0};
  logic center_exp[12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};

  initial begin
    @(negedge clock);
    reset_n = 1'b0;
    cyc(); cyc();
    chk("reset_out", 32'(pwm_out), 32'd0);
    reset_n = 1'b1; enable = 1'b1;
    repeat (6) cyc();

    // edge basic
    enable = 1'b0;
    set_cfg(0, 3, 0, 2, 0, 4, 1, 0);
    cyc();
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin cyc(); seq[k] = pwm_out[0]; end
    for (int k = 0; k < 8; k++) chk("edge_seq", 32'(seq[k]), 32'(edge_exp[k]));
    // shadow load mid-period, then wait across the wrap
    cyc();
    set_cfg(0, 3, 0, 3, 1, 0, 2, 0);
    repeat (12) cyc();

    // prescaler
    enable = 1'b0;
    set_cfg(2, 1, 0, 1, 2, 0, 1, 4'b0101);
    cyc();
    enable = 1'b1;
    repeat (18) cyc();

    // center
    enable = 1'b0;
    set_cfg(0, 3, 1, 2, 3, 4, 0, 0);
    cyc();
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin cyc(); seq[k] = pwm_out[0]; end
    for (int k = 0; k < 12; k++) chk("center_seq", 32'(seq[k]), 32'(center_exp[k]));

    // extremes: duty 0, duty top+1, inverted duty 0
    enable = 1'b0;
    set_cfg(0, 3, 0, 0, 4, 0, 2, 4'b0100);
    cyc();
    enable = 1'b1;
    repeat (10) cyc();
    chk("duty_extremes", 32'(pwm_out[2:0]), 32'b110);
    enable = 1'b0;
    cyc();
    chk("disabled_out", 32'(pwm_out), 32'b0100);

    // reset mid-period with inversion
    set_cfg(1, 5, 0, 3, 3, 3, 3, 4'b1111);
    cyc();
    enable = 1'b1;
    repeat (5) cyc();
    reset_n = 1'b0;
    cyc();
    chk("reset_mid", 32'(pwm_out), 32'd0);
    reset_n = 1'b1;
    repeat (6) cyc();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset_n = ($urandom_range(0, 799) != 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      load = ($urandom_range(0, 24) == 0);
      if (load) begin
        prescaler = PW'($urandom_range(0, 3));
        top = W'($urandom_range(0, 9));
        mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < CH; i++)
          duty[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, int'(top) + 2));
        invert = CH'($urandom);
      end
      cyc();
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
